axi_lite_master_arbiter: RTL and testbench

Two-requester AXI4-Lite master. It arbitrates simple register-access commands from two local clients and sequences each granted command onto one AXI4-Lite master port. The port drives the S_Axi_Lite register slave. At most one AXI transaction is outstanding. Arbitration is round-robin, and each client gets a one-cycle completion pulse carrying the response.

---
 rtl/axi_lite_master_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_axi_lite_master_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_arbiter.sv
// rtl/axi_lite_master_arbiter.sv - Two-client round-robin arbiter driving one AXI4-Lite master port
// One transaction in flight at a time; every output is a register.
module axi_lite_master_arbiter #(
   parameter int P_ADDR_WIDTH = 32,
   parameter int P_DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [1:0]                      REQ,
   input  logic [1:0]                      REQ_WE,
   input  logic [2*P_ADDR_WIDTH-1:0]       REQ_ADDR,
   input  logic [2*P_DATA_WIDTH-1:0]       REQ_WDATA,
   input  logic [2*(P_DATA_WIDTH/8)-1:0]   REQ_WSTRB,
   output logic [1:0]                      GNT,
   output logic [1:0]                      DONE,
   output logic [P_DATA_WIDTH-1:0]         RSP_RDATA,
   output logic [1:0]                      RSP_RESP,
   output logic                            BUSY,
   output logic [P_ADDR_WIDTH-1:0]         M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [P_DATA_WIDTH-1:0]         M_AXI_WDATA,
   output logic [P_DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [P_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [P_DATA_WIDTH-1:0]         M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int AW = P_ADDR_WIDTH;
   localparam int DW = P_DATA_WIDTH;
   localparam int SW = P_DATA_WIDTH / 8;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA} state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_q, last_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic            bready_q, bready_d, rready_q, rready_d;
   logic [1:0]      gnt_q, gnt_d, done_q, done_d, resp_q, resp_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            busy_q, busy_d;
   logic            win, aw_left, w_left;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      bready_d  = bready_q;
      rready_d  = rready_q;
      gnt_d     = 2'b00;
      done_d    = 2'b00;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      win       = 1'b0;
      aw_left   = 1'b0;
      w_left    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (REQ != 2'b00) begin
               // last_q names the previous winner, so the other client wins a tie
               win     = (REQ == 2'b11) ? ~last_q : REQ[1];
               owner_d = win;
               last_d  = win;
               addr_d  = win ? REQ_ADDR[AW +: AW] : REQ_ADDR[0 +: AW];
               wdata_d = win ? REQ_WDATA[DW +: DW] : REQ_WDATA[0 +: DW];
               wstrb_d = win ? REQ_WSTRB[SW +: SW] : REQ_WSTRB[0 +: SW];
               gnt_d   = win ? 2'b10 : 2'b01;
               if (REQ_WE[win]) begin
                  state_d   = S_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR: begin
            // AW and W retire independently; leave once neither is still pending
            aw_left   = awvalid_q && !M_AXI_AWREADY;
            w_left    = wvalid_q && !M_AXI_WREADY;
            awvalid_d = aw_left;
            wvalid_d  = w_left;
            if (!aw_left && !w_left) begin
               state_d  = S_WR_RESP;
               bready_d = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (M_AXI_BVALID && bready_q) begin
               bready_d = 1'b0;
               resp_d   = M_AXI_BRESP;
               done_d   = owner_q ? 2'b10 : 2'b01;
               state_d  = S_IDLE;
            end
         end
         S_RD_ADDR: begin
            if (arvalid_q && M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (M_AXI_RVALID && rready_q) begin
               rready_d = 1'b0;
               rdata_d  = M_AXI_RDATA;
               resp_d   = M_AXI_RRESP;
               done_d   = owner_q ? 2'b10 : 2'b01;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= S_IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         bready_q  <= 1'b0;
         rready_q  <= 1'b0;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         resp_q    <= 2'b00;
         rdata_q   <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         bready_q  <= bready_d;
         rready_q  <= rready_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
      end
   end

   assign GNT           = gnt_q;
   assign DONE          = done_q;
   assign RSP_RDATA     = rdata_q;
   assign RSP_RESP      = resp_q;
   assign BUSY          = busy_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb/tb_axi_lite_master_arbiter.sv - Self-checking bench for axi_lite_master_arbiter
// Register-slave model plus a transaction-level scoreboard of grants and completions.
module tb_axi_lite_master_arbiter;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [1:0]  REQ, REQ_WE;
   logic [63:0] REQ_ADDR, REQ_WDATA;
   logic [7:0]  REQ_WSTRB;
   logic [1:0]  GNT, DONE, RSP_RESP;
   logic [31:0] RSP_RDATA;
   logic        BUSY;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   always #5 ACLK = ~ACLK;

   axi_lite_master_arbiter #(.P_ADDR_WIDTH(32), .P_DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .REQ(REQ), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB),
      .GNT(GNT), .DONE(DONE), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .BUSY(BUSY),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register slave: 16 words, address 0x10 answers SLVERR and ignores writes
   int aw_stall = 0, w_stall = 0, ar_stall = 0;
   int aw_cnt, w_cnt, ar_cnt;
   logic [31:0] s_mem [16];
   logic        s_got_aw, s_got_w;
   logic [31:0] s_awaddr, s_wdata;
   logic [3:0]  s_wstrb;

   assign M_AXI_AWREADY = (aw_cnt >= aw_stall);
   assign M_AXI_WREADY  = (w_cnt >= w_stall);
   assign M_AXI_ARREADY = (ar_cnt >= ar_stall);

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         s_got_aw <= 1'b0; s_got_w <= 1'b0;
         s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
         M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
         M_AXI_RVALID <= 1'b0; M_AXI_RDATA <= '0; M_AXI_RRESP <= 2'b00;
         for (int i = 0; i < 16; i++) s_mem[i] <= '0;
      end else begin
         if (M_AXI_AWVALID) aw_cnt <= M_AXI_AWREADY ? 0 : aw_cnt + 1;
         if (M_AXI_WVALID)  w_cnt  <= M_AXI_WREADY  ? 0 : w_cnt + 1;
         if (M_AXI_ARVALID) ar_cnt <= M_AXI_ARREADY ? 0 : ar_cnt + 1;
         if (M_AXI_AWVALID && M_AXI_AWREADY) begin s_got_aw <= 1'b1; s_awaddr <= M_AXI_AWADDR; end
         if (M_AXI_WVALID && M_AXI_WREADY) begin s_got_w <= 1'b1; s_wdata <= M_AXI_WDATA; s_wstrb <= M_AXI_WSTRB; end
         if (s_got_aw && s_got_w && !M_AXI_BVALID) begin
            if (s_awaddr == 32'h10) M_AXI_BRESP <= 2'b10;
            else begin
               M_AXI_BRESP <= 2'b00;
               for (int b = 0; b < 4; b++)
                  if (s_wstrb[b]) s_mem[s_awaddr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
            M_AXI_BVALID <= 1'b1; s_got_aw <= 1'b0; s_got_w <= 1'b0;
         end
         if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_RVALID <= 1'b1;
            M_AXI_RDATA  <= s_mem[M_AXI_ARADDR[5:2]];
            M_AXI_RRESP  <= (M_AXI_ARADDR == 32'h10) ? 2'b10 : 2'b00;
         end
         if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      end
   end

   typedef struct {
      int          client;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } cmd_t;

   // Reference model: expected in-flight command, register image, last winner
   cmd_t        exp_q[$];
   cmd_t        cq0[$], cq1[$];
   logic [31:0] m_mem [16];
   int          m_last = 1;
   int          cyc = 0;
   int          gnt_log[$], gnt_cyc[$], done_cyc[$];
   int          awv_cycles = 0, wv_cycles = 0, done_cnt = 0;
   logic [1:0]  last_done = 2'b00, last_resp = 2'b00;
   logic [31:0] last_rdata = '0;
   logic        p_busy = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
   logic [31:0] p_awaddr, p_wdata, p_araddr;

   always @(posedge ACLK) begin
      int   win;
      cmd_t c;
      logic [1:0] er;
      #1;
      cyc++;
      if (ARESET) begin
         exp_q.delete();
         m_last = 1;
         for (int i = 0; i < 16; i++) m_mem[i] = '0;
         p_busy = 1'b0; p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
      end else begin
         if (!p_busy) begin
            if (REQ != 2'b00) begin
               win = (REQ == 2'b11) ? 1 - m_last : (REQ[1] ? 1 : 0);
               chk("gnt_winner", GNT, (win == 1) ? 2'b10 : 2'b01);
               c.client = win;
               c.we     = REQ_WE[win];
               c.addr   = REQ_ADDR[win*32 +: 32];
               c.wdata  = REQ_WDATA[win*32 +: 32];
               c.strb   = REQ_WSTRB[win*4 +: 4];
               exp_q.push_back(c);
               m_last = win;
               gnt_log.push_back(win);
               gnt_cyc.push_back(cyc);
            end else chk("gnt_no_req", GNT, 2'b00);
         end else chk("gnt_while_busy", GNT, 2'b00);

         if (DONE != 2'b00) begin
            if (exp_q.size() == 0) chk("done_unexpected", DONE, 2'b00);
            else begin
               c  = exp_q.pop_front();
               er = (c.addr == 32'h10) ? 2'b10 : 2'b00;
               chk("done_owner", DONE, (c.client == 1) ? 2'b10 : 2'b01);
               chk("rsp_resp", RSP_RESP, er);
               if (!c.we) chk("rsp_rdata", RSP_RDATA, m_mem[c.addr[5:2]]);
               else if (er == 2'b00)
                  for (int b = 0; b < 4; b++)
                     if (c.strb[b]) m_mem[c.addr[5:2]][8*b +: 8] = c.wdata[8*b +: 8];
               last_done = DONE; last_resp = RSP_RESP; last_rdata = RSP_RDATA;
               done_cyc.push_back(cyc);
               done_cnt++;
            end
         end
         chk("busy", BUSY, exp_q.size() != 0);

         if (exp_q.size() != 0) begin
            if (M_AXI_AWVALID) begin
               chk("awaddr", M_AXI_AWADDR, exp_q[0].addr);
               chk("awprot", M_AXI_AWPROT, 3'b000);
            end
            if (M_AXI_WVALID) chk("wdata_wstrb", {M_AXI_WSTRB, M_AXI_WDATA}, {exp_q[0].strb, exp_q[0].wdata});
            if (M_AXI_ARVALID) begin
               chk("araddr", M_AXI_ARADDR, exp_q[0].addr);
               chk("arprot", M_AXI_ARPROT, 3'b000);
            end
         end
         if (p_awv && !p_awr) chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, p_awaddr});
         if (p_wv && !p_wr)   chk("w_hold", {M_AXI_WVALID, M_AXI_WDATA}, {1'b1, p_wdata});
         if (p_arv && !p_arr) chk("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, p_araddr});
         if (M_AXI_BREADY) chk("bready_after_hs", M_AXI_AWVALID | M_AXI_WVALID, 1'b0);
         if (M_AXI_AWVALID) awv_cycles++;
         if (M_AXI_WVALID) wv_cycles++;

         p_busy = BUSY;
         p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
         p_wv = M_AXI_WVALID;   p_wr = M_AXI_WREADY;   p_wdata = M_AXI_WDATA;
         p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
      end
   end

   task automatic drive(input int i, input cmd_t c);
      REQ[i]              = 1'b1;
      REQ_WE[i]           = c.we;
      REQ_ADDR[i*32 +: 32]  = c.addr;
      REQ_WDATA[i*32 +: 32] = c.wdata;
      REQ_WSTRB[i*4 +: 4]   = c.strb;
   endtask

   // Clients present queued commands; a granted client re-validates with its next one at once
   task automatic run_traffic(input int max_cycles, input bit rnd);
      int   n;
      cmd_t c;
      n = 0;
      while ((cq0.size() != 0 || cq1.size() != 0 || REQ != 2'b00 || exp_q.size() != 0) && n < max_cycles) begin
         @(negedge ACLK);
         n++;
         for (int i = 0; i < 2; i++) begin
            if (REQ[i] && GNT[i]) REQ[i] = 1'b0;
            if (!REQ[i] && (!rnd || $urandom_range(3) != 0)) begin
               if (i == 0 && cq0.size() != 0) begin c = cq0.pop_front(); drive(0, c); end
               else if (i == 1 && cq1.size() != 0) begin c = cq1.pop_front(); drive(1, c); end
            end
         end
      end
      chk("traffic_timeout", n >= max_cycles, 1'b0);
   endtask

   function automatic cmd_t mk(input int cl, input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_t c;
      c.client = cl; c.we = we; c.addr = a; c.wdata = d; c.strb = s;
      return c;
   endfunction

   typedef struct {
      cmd_t        c;
      logic [1:0]  e_done;
      logic [1:0]  e_resp;
      logic [31:0] e_rdata;
   } vec_t;

   function automatic vec_t mv(input cmd_t c, input logic [1:0] d, input logic [1:0] r, input logic [31:0] rd);
      vec_t v;
      v.c = c; v.e_done = d; v.e_resp = r; v.e_rdata = rd;
      return v;
   endfunction

   initial begin
      vec_t vt [7];
      cmd_t c;
      int   n;
      vt[0] = mv(mk(0, 1, 32'h4,  32'h6,        4'hF),  2'b01, 2'b00, 32'h0);
      vt[1] = mv(mk(1, 0, 32'h4,  32'h0,        4'h0),  2'b10, 2'b00, 32'h6);
      vt[2] = mv(mk(0, 1, 32'h8,  32'hAABBCCDD, 4'h5),  2'b01, 2'b00, 32'h0);
      vt[3] = mv(mk(1, 0, 32'h8,  32'h0,        4'h0),  2'b10, 2'b00, 32'h00BB00DD);
      vt[4] = mv(mk(1, 0, 32'h10, 32'h0,        4'h0),  2'b10, 2'b10, 32'h0);
      vt[5] = mv(mk(0, 1, 32'h10, 32'h55,       4'hF),  2'b01, 2'b10, 32'h0);
      vt[6] = mv(mk(1, 0, 32'h0,  32'h0,        4'h0),  2'b10, 2'b00, 32'h0);

      ARESET = 1'b1; REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_WSTRB = '0;
      repeat (3) @(negedge ACLK);
      chk("rst_gnt_done_busy", {GNT, DONE, BUSY}, 5'b0);
      chk("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
      chk("rst_rsp", {RSP_RESP, RSP_RDATA}, 34'b0);
      chk("rst_addr_data", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}, 68'b0);
      @(negedge ACLK) ARESET = 1'b0;

      for (int k = 0; k < 7; k++) begin
         if (vt[k].c.client == 0) cq0.push_back(vt[k].c); else cq1.push_back(vt[k].c);
         run_traffic(200, 1'b0);
         chk("tbl_done", last_done, vt[k].e_done);
         chk("tbl_resp", last_resp, vt[k].e_resp);
         if (!vt[k].c.we) chk("tbl_rdata", last_rdata, vt[k].e_rdata);
      end

      gnt_log.delete(); gnt_cyc.delete(); done_cyc.delete();
      cq0.push_back(mk(0, 1, 32'h0, 32'h11, 4'hF)); cq0.push_back(mk(0, 1, 32'h0, 32'h11, 4'hF));
      cq1.push_back(mk(1, 1, 32'h8, 32'h22, 4'hF)); cq1.push_back(mk(1, 1, 32'h8, 32'h22, 4'hF));
      run_traffic(200, 1'b0);
      chk("rr_count", gnt_log.size(), 4);
      chk("rr_done_count", done_cyc.size(), 4);
      if (gnt_log.size() == 4 && done_cyc.size() == 4)
         for (int k = 0; k < 4; k++) begin
            chk("rr_order", gnt_log[k], k % 2);
            if (k > 0) chk("rr_gap", gnt_cyc[k] - done_cyc[k-1], 1);
         end

      aw_stall = 3; awv_cycles = 0; wv_cycles = 0; done_cnt = 0;
      cq0.push_back(mk(0, 1, 32'hC, 32'h12345678, 4'hF));
      run_traffic(200, 1'b0);
      chk("stall_awvalid_cycles", awv_cycles, 4);
      chk("stall_wvalid_cycles", wv_cycles, 1);
      chk("stall_done_pulses", done_cnt, 1);
      aw_stall = 0;

      for (int b = 0; b < 3; b++) begin
         aw_stall = (b == 1) ? 2 : 0;
         w_stall  = (b == 2) ? 3 : 0;
         ar_stall = b;
         for (int k = 0; k < 40; k++) begin
            c = mk(0, 1'($urandom_range(1)), 32'($urandom_range(15)) << 2, $urandom, 4'($urandom_range(15)));
            if ($urandom_range(1) == 1) begin c.client = 1; cq1.push_back(c); end
            else cq0.push_back(c);
         end
         run_traffic(4000, 1'b1);
      end
      aw_stall = 0; w_stall = 0; ar_stall = 0;

      @(negedge ACLK) drive(0, mk(0, 1, 32'h14, 32'h77, 4'hF));
      n = 0;
      while (!GNT[0] && n < 20) begin @(negedge ACLK); n++; end
      REQ[0] = 1'b0;
      while (!M_AXI_BREADY && n < 20) begin @(negedge ACLK); n++; end
      chk("reach_wr_resp", M_AXI_BREADY, 1'b1);
      #2 ARESET = 1'b1;
      #1;
      chk("async_rst_axi", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
      chk("async_rst_ctl", {GNT, DONE, BUSY}, 5'b0);
      drive(0, mk(0, 1, 32'h20, 32'hCAFE, 4'hF));
      drive(1, mk(1, 0, 32'h20, 32'h0, 4'h0));
      gnt_log.delete();
      @(negedge ACLK) ARESET = 1'b0;
      run_traffic(200, 1'b0);
      chk("post_rst_first", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);
      chk("post_rst_second", (gnt_log.size() > 1) ? gnt_log[1] : 99, 1);
      chk("post_rst_rdata", last_rdata, 32'hCAFE);

      repeat (2) @(negedge ACLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
